// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, counter sizing.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIXUP
    } state_t;

    // Iteration counter must hold 0..width.
    function automatic int unsigned iterCntWidth(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division step: shift-in partial remainder vs divisor -> next remainder and quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remNext_c,
    output logic             qBit_c
);

    logic [WIDTH-1:0] diff;

    // Subtract when the divisor fits; otherwise restore (keep the shifted remainder).
    always_comb begin
        qBit_c    = (partial >= {1'b0, divisor});
        diff      = partial[WIDTH-1:0] - divisor;
        remNext_c = qBit_c ? diff : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, one result bit per cycle, flushable.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = iterCntWidth(WIDTH);

    state_t             state;
    logic [CW-1:0]      iterCnt;
    logic [2*WIDTH-1:0] acc;          // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opB;          // multiplicand or divisor magnitude
    logic               negResult;
    logic               negRem;
    logic               isDivOp;
    logic               divZero;

    logic               isSignedOp;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [2*WIDTH-1:0] divNext;
    logic [WIDTH-1:0]   remNext;
    logic               qBit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    div_step #(.WIDTH(WIDTH)) uDivStep (
        .partial   ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor   (opB),
        .remNext_c (remNext),
        .qBit_c    (qBit)
    );

    // Operand magnitudes at issue and the shift-add multiply step.
    always_comb begin
        isSignedOp = (op == OP_MULT) || (op == OP_DIV);
        aNeg       = isSignedOp & src_a[WIDTH-1];
        bNeg       = isSignedOp & src_b[WIDTH-1];
        absA       = aNeg ? -src_a : src_a;
        absB       = bNeg ? -src_b : src_b;
        mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opB : WIDTH'(0))};
        mulNext    = {mulSum, acc[WIDTH-1:1]};
        divNext    = {remNext, acc[WIDTH-2:0], qBit};
    end

    // Sign fixup of the finished magnitude result; divide-by-zero forces LO to all ones.
    always_comb begin
        prod  = negResult ? -acc : acc;
        quo   = acc[WIDTH-1:0];
        rem   = acc[2*WIDTH-1:WIDTH];
        fixHi = prod[2*WIDTH-1:WIDTH];
        fixLo = prod[WIDTH-1:0];
        if (isDivOp) begin
            fixHi = negRem ? -rem : rem;
            fixLo = divZero ? {WIDTH{1'b1}} : (negResult ? -quo : quo);
        end
    end

    // FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            iterCnt     <= '0;
            acc         <= '0;
            opB         <= '0;
            negResult   <= 1'b0;
            negRem      <= 1'b0;
            isDivOp     <= 1'b0;
            divZero     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (flush) begin
                state   <= ST_IDLE;
                iterCnt <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            case (op)
                                OP_MULT, OP_MULTU: begin
                                    acc       <= {WIDTH'(0), absB};
                                    opB       <= absA;
                                    negResult <= aNeg ^ bNeg;
                                    isDivOp   <= 1'b0;
                                    iterCnt   <= '0;
                                    busy      <= 1'b1;
                                    state     <= ST_MUL;
                                end
                                OP_DIV, OP_DIVU: begin
                                    acc       <= {WIDTH'(0), absA};
                                    opB       <= absB;
                                    negResult <= aNeg ^ bNeg;
                                    negRem    <= aNeg;
                                    divZero   <= (src_b == '0);
                                    isDivOp   <= 1'b1;
                                    iterCnt   <= '0;
                                    busy      <= 1'b1;
                                    state     <= ST_DIV;
                                end
                                OP_MTHI: hi <= src_a;
                                OP_MTLO: lo <= src_a;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        acc <= (state == ST_MUL) ? mulNext : divNext;
                        if (iterCnt == CW'(WIDTH - 1)) begin
                            iterCnt <= '0;
                            state   <= ST_FIXUP;
                        end else begin
                            iterCnt <= iterCnt + CW'(1);
                        end
                    end
                    ST_FIXUP: begin
                        hi          <= fixHi;
                        lo          <= fixLo;
                        done        <= 1'b1;
                        div_by_zero <= isDivOp & divZero;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH = 32.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] srcA;
    logic [W-1:0] srcB;
    logic         flush;
    logic         busy;
    logic         done;
    logic         divByZero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int compared   = 0;
    int mismatched = 0;
    logic [W-1:0] expHi;
    logic [W-1:0] expLo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .src_a       (srcA),
        .src_b       (srcB),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (divByZero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one issue in the current cycle; returns one cycle later with junk on the operand inputs.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = OP_MTHI;
        srcA  = $urandom;
        srcB  = $urandom;
    endtask

    // Called in cycle 1 after an issue: busy through cycle 33, done plus result in cycle 34.
    task automatic expectResult(input string tag, input logic [W-1:0] h, input logic [W-1:0] l, input logic dbz);
        for (int c = 1; c <= 33; c++) begin
            check($sformatf("%s_run_c%0d", tag, c), W'({busy, done, divByZero}), W'(3'b100));
            tick();
        end
        check($sformatf("%s_done", tag), W'({busy, done, divByZero}), W'({1'b0, 1'b1, dbz}));
        check($sformatf("%s_hi", tag), hi, h);
        check($sformatf("%s_lo", tag), lo, l);
        expHi = h;
        expLo = l;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = OP_MULT;
        srcA  = '0;
        srcB  = '0;
        #1;
        check("reset_status", W'({busy, done, divByZero}), W'(3'b000));
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Signed multiply, then back-to-back unsigned multiply issued in the done cycle.
        issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
        expectResult("mult_7xm3", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expectResult("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        // Divides including signed overflow and divide by zero.
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        expectResult("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        issue(OP_DIVU, 32'd100, 32'd7);
        expectResult("divu_100_7", 32'h0000_0002, 32'h0000_000E, 1'b0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expectResult("div_ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);
        issue(OP_DIVU, 32'd5, 32'd0);
        expectResult("divu_by0", 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        expectResult("div_m7_by0", 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
        tick();
        check("idle_after_done", W'({busy, done, divByZero}), W'(3'b000));

        // MTLO writes LO next cycle without going busy.
        issue(OP_MTLO, 32'h0000_1234, 32'd0);
        expLo = 32'h0000_1234;
        check("mtlo_lo", lo, expLo);
        check("mtlo_hi", hi, expHi);
        check("mtlo_status", W'({busy, done, divByZero}), W'(3'b000));
        tick();
        check("mtlo_status2", W'({busy, done, divByZero}), W'(3'b000));

        // MULT flushed at cycle 10, with an MTHI start attempted while busy.
        issue(OP_MULT, 32'd5, 32'd6);
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("flush_run_c%0d", c), W'(busy), W'(1'b1));
            if (c == 5) begin
                start = 1'b1;
                op    = OP_MTHI;
                srcA  = 32'hDEAD_BEEF;
            end
            tick();
            start = 1'b0;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy_c11", W'(busy), W'(1'b0));
        for (int c = 0; c < 30; c++) begin
            check($sformatf("flush_quiet_%0d", c), W'({busy, done, divByZero}), W'(3'b000));
            tick();
        end
        check("flush_hi", hi, expHi);
        check("flush_lo", lo, expLo);

        // Flush landing in FIXUP suppresses the result.
        issue(OP_MULTU, 32'd2, 32'd3);
        for (int c = 1; c <= 32; c++) tick();
        check("fixup_busy_c33", W'(busy), W'(1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fixup_flush_status", W'({busy, done, divByZero}), W'(3'b000));
        check("fixup_flush_hi", hi, expHi);
        check("fixup_flush_lo", lo, expLo);

        // start and flush together in IDLE issue nothing.
        op    = OP_MTHI;
        srcA  = 32'h0000_AAAA;
        start = 1'b1;
        flush = 1'b1;
        tick();
        check("stflush_mthi_hi", hi, expHi);
        op = OP_MULT;
        srcA = 32'd9;
        srcB = 32'd9;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("stflush_mult_busy", W'(busy), W'(1'b0));
        tick();
        check("stflush_mult_busy2", W'({busy, done, divByZero}), W'(3'b000));

        // Asynchronous reset mid-divide clears state before the next edge.
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int c = 1; c <= 19; c++) tick();
        check("rstmid_busy_before", W'(busy), W'(1'b1));
        #3;
        reset = 1'b1;
        #1;
        check("rstmid_busy", W'(busy), W'(1'b0));
        check("rstmid_hi", hi, 32'h0);
        check("rstmid_lo", lo, 32'h0);
        #1;
        reset = 1'b0;
        tick();
        check("rstmid_idle", W'({busy, done, divByZero}), W'(3'b000));
        issue(OP_MULTU, 32'd3, 32'd4);
        expectResult("multu_3x4", 32'h0, 32'd12, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width, serving the execute stage of the pipelined MIPS core. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO issue per idle cycle and computes products and quotients one bit per cycle. While it works, it holds `busy` high so the hazard unit can stall dependent MFHI/MFLO and further mul/div issues. It also supports abort on pipeline flush.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits. Must be ≥ 4.
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: issue valid from the execute stage, sampled only in IDLE.
- `op`, in, 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others no-op.
- `src_a`, in, WIDTH: multiplicand / dividend / MT source.
- `src_b`, in, WIDTH: multiplier / divisor.
- `flush`, in, 1: aborts any operation in progress, or the issue in the same cycle.
- `busy`, out, 1: high while an operation is in progress.
- `done`, out, 1: one-cycle pulse; HI/LO hold the new result in that cycle.
- `div_by_zero`, out, 1: pulses together with `done` for DIV/DIVU when `src_b == 0`.
- `hi`, `lo`, out, WIDTH each: architectural HI/LO registers.

## Operation
- States:
  - IDLE
  - MUL (WIDTH cycles)
  - DIV (WIDTH cycles)
  - FIXUP (1 cycle)
- Transitions:
  - IDLE → MUL on `start & ~flush` with op 0/1.
  - IDLE → DIV on `start & ~flush` with op 2/3.
  - MUL/DIV → FIXUP after WIDTH iterations.
  - FIXUP → IDLE.
  - Any state → IDLE on `flush`.
- MTHI/MTLO: in IDLE with `start & ~flush`, write `src_a` to HI/LO at the next edge. `busy` and `done` stay low; state stays IDLE.
- Operand latch: `src_a`/`src_b` are captured at issue. Inputs are ignored afterwards.
- `start` while busy: ignored entirely. The hazard unit guarantees it does not happen; the bench checks that it is ignored.
- Multiply: shift-add on a 2·WIDTH accumulator, one bit per cycle. Signed ops work on magnitudes, and FIXUP negates the 2·WIDTH product if the operand signs differ.
- Divide: restoring division, one quotient bit per cycle. LO = quotient, HI = remainder. Signed ops work on magnitudes. FIXUP negates the quotient if the signs differ and gives the remainder the sign of the dividend.
- Signed overflow: most-negative ÷ −1 gives LO = most-negative, HI = 0 (natural wrap).
- Divide by zero: HI = dividend, LO = all ones, `div_by_zero` = 1. It takes the same latency as a normal divide.
- Flush in MUL/DIV/FIXUP: state returns to IDLE at the next edge. HI/LO are unchanged and `done` is not pulsed.

## Timing
- Issue accepted at edge of cycle T. `busy` = 1 in cycles T+1 … T+WIDTH+1 (MUL/DIV then FIXUP).
- `done` = 1 in cycle T+WIDTH+2 only. HI/LO are updated at the same edge, with `busy` = 0.
- For WIDTH = 32, issue at cycle 0 gives `done` at cycle 34.
- Back-to-back: a new `start` is accepted in the `done` cycle. HI/LO may be read (MFHI/MFLO) combinationally in that cycle.
- Flush seen in cycle F: `busy` = 0 from F+1.
- Reset values, applied immediately on `reset` rise (async), including mid-operation: state IDLE, `busy` = 0, `done` = 0, `div_by_zero` = 0, `hi` = 0, `lo` = 0, iteration counter 0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - the op encoding constants (OP_MULT … OP_MTLO)
  - the state enum
  - the iteration counter width, `$clog2(WIDTH+1)`
- One sub-module, `div_step`: a combinational restoring-divide step (partial remainder, divisor → next remainder, quotient bit), instantiated once.
- The multiply step, sign fixup and FSM live in `muldiv_unit`.

## Test plan
All scenarios use WIDTH = 32.
- MULT 7 × 0xFFFFFFFD (−3), issued at cycle 0 → `busy` in cycles 1–33; at cycle 34 `done` = 1, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then MULTU 0xFFFFFFFF × 0xFFFFFFFF issued in the `done` cycle → hi = 0xFFFFFFFE, lo = 0x00000001, 34 cycles later.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU 100 ÷ 7 → lo = 0x0000000E, hi = 0x00000002. DIV 0x80000000 ÷ 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 5 ÷ 0 → at cycle 34, `done` = `div_by_zero` = 1, hi = 5, lo = 0xFFFFFFFF. `div_by_zero` = 0 on all other cycles.
- MTLO 0x1234 → lo = 0x1234 next cycle, `busy` never high. Then MULT issued and `flush` at cycle 10 → `busy` = 0 from cycle 11, no `done`, hi/lo unchanged. A `start` with op MTHI during `busy` → ignored.
- `start` and `flush` in the same IDLE cycle → nothing issued, hi/lo unchanged.
- `reset` pulsed mid-DIV at cycle 20, asynchronously between edges → `busy`/`hi`/`lo` = 0 before the next edge. The unit then accepts a new MULTU 3 × 4 → lo = 12, hi = 0.
